mem_responder: RTL and testbench

Synchronous single-port 32x8 memory that answers the read/write/addr/data_in command set issued by the memory test bench, returning read data on data_out. Adds a self-timed clear engine, a command-collision flag and saturating access counters, so the bench can check both data integrity and protocol conformance. Sits as the DUT opposite the bench in the memory lab top level.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the memory responder.
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
module mem_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Command responder for the 32x8 memory: arbitration, clear engine,
// sticky collision flag and saturating access counters.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int CNT_W  = mem_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              clear,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        arr_we    = 1'b0;
        arr_waddr = addr;
        arr_wdata = data_in;
        arr_re    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (read && write) begin
                    err_d = 1'b1;
                end
                // Clear wins over any command sampled in the same cycle.
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (write && !read) begin
                    arr_we   = 1'b1;
                    wr_cnt_d = sat_inc(wr_cnt_q);
                end else if (read && !write) begin
                    arr_re   = 1'b1;
                    rd_cnt_d = sat_inc(rd_cnt_q);
                end
            end
            CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = ptr_q;
                arr_wdata = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (addr),
        .rdata (data_out)
    );

    assign busy     = (state_q == CLEAR);
    assign err      = err_q;
    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        clear;
    logic        busy;
    logic        err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int checks   = 0;
    int failures = 0;

    mem_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .clear    (clear),
        .busy     (busy),
        .err      (err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command cycle: drive at negedge, sample 1ns after the next rising edge.
    task automatic op(input logic rd, input logic wr, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = d;
        tick();
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        clear   = 1'b0;
        addr    = '0;
        data_in = '0;

        repeat (3) tick();
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_data_out", 32'(data_out), 32'h0);

        // Clear: busy for exactly 32 cycles, then array reads zero.
        pulse_clear();
        chk("clr_busy_rise", 32'(busy), 32'h1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        chk("clr_busy_len", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            op(1'b1, 1'b0, 5'(a), 8'h00);
            chk($sformatf("clr_rd%0d", a), 32'(data_out), 32'h0);
        end
        chk("clr_rd_count", 32'(rd_count), 32'd32);
        chk("clr_wr_count", 32'(wr_count), 32'd0);

        // Address pattern write and read-back.
        for (int a = 0; a < 32; a++) op(1'b0, 1'b1, 5'(a), 8'(a));
        for (int a = 0; a < 32; a++) begin
            op(1'b1, 1'b0, 5'(a), 8'h00);
            chk($sformatf("pat_rd%0d", a), 32'(data_out), 32'(a));
        end
        chk("pat_wr_count", 32'(wr_count), 32'd32);
        chk("pat_rd_count", 32'(rd_count), 32'd64);

        // Write at edge N visible to read at N+1.
        op(1'b0, 1'b1, 5'd7, 8'hA5);
        op(1'b1, 1'b0, 5'd7, 8'h00);
        chk("wr_rd_b2b", 32'(data_out), 32'hA5);

        // Collision: no access, data_out and counters hold, err sticks.
        op(1'b0, 1'b1, 5'd3, 8'h3C);
        op(1'b1, 1'b0, 5'd5, 8'h00);
        chk("pre_col_rd5", 32'(data_out), 32'h05);
        op(1'b1, 1'b1, 5'd3, 8'h99);
        chk("col_data_hold", 32'(data_out), 32'h05);
        chk("col_err", 32'(err), 32'h1);
        chk("col_wr_count", 32'(wr_count), 32'd34);
        chk("col_rd_count", 32'(rd_count), 32'd66);
        op(1'b1, 1'b0, 5'd3, 8'h00);
        chk("col_mem3", 32'(data_out), 32'h3C);
        op(1'b0, 1'b1, 5'd10, 8'h10);
        chk("col_err_sticky", 32'(err), 32'h1);
        chk("post_col_wr", 32'(wr_count), 32'd35);

        // Reset in the middle of a clear: words 0..8 zeroed, word 9 intact.
        pulse_clear();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            write   = (i == 2);
            addr    = 5'd2;
            data_in = 8'hFF;
            tick();
            write = 1'b0;
        end
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_data_hold", 32'(data_out), 32'h3C);
        chk("mid_wr_count", 32'(wr_count), 32'd35);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wr_count", 32'(wr_count), 32'h0);
        chk("abort_rd_count", 32'(rd_count), 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        chk("abort_data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 9; a++) begin
            op(1'b1, 1'b0, 5'(a), 8'h00);
            chk($sformatf("abort_rd%0d", a), 32'(data_out), 32'h0);
        end
        op(1'b1, 1'b0, 5'd9, 8'h00);
        chk("abort_rd9_kept", 32'(data_out), 32'h09);
        chk("abort_rd_count2", 32'(rd_count), 32'd10);

        // Write counter saturation.
        @(negedge clk);
        write   = 1'b1;
        addr    = 5'd31;
        data_in = 8'h5A;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_wr_fffe", 32'(wr_count), 32'hFFFE);
        tick();
        chk("sat_wr_ffff", 32'(wr_count), 32'hFFFF);
        tick();
        chk("sat_wr_hold", 32'(wr_count), 32'hFFFF);
        write = 1'b0;
        op(1'b1, 1'b0, 5'd31, 8'h00);
        chk("sat_rd31", 32'(data_out), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
